// File: rtl/seq_detect_pkg.sv
// Shared constants and elaboration-time helpers for the serial sequence detector.
// The helpers compute the KMP fallback lengths that the detector bakes into its
// next-state table for each parameter set.
package seq_detect_pkg;

    localparam int MAX_PAT_LEN = 16;

    // Bit i of the pattern counted in arrival order (i = 0 is the first bit received).
    function automatic logic pat_bit(
        input logic [MAX_PAT_LEN-1:0] pattern,
        input int                     len,
        input int                     idx
    );
        logic [MAX_PAT_LEN-1:0] shifted;
        shifted = pattern >> (len - 1 - idx);
        return shifted[0];
    endfunction

    // Length of the longest proper prefix of the pattern that is a suffix of
    // (the first k pattern bits followed by b).
    function automatic int fail_len(
        input logic [MAX_PAT_LEN-1:0] pattern,
        input int                     len,
        input int                     k,
        input logic                   b
    );
        int   best;
        int   limit;
        int   pos;
        logic ok;
        logic sbit;
        best  = 0;
        limit = (k + 1 < len - 1) ? k + 1 : len - 1;
        for (int l = 1; l <= MAX_PAT_LEN; l++) begin
            if (l <= limit) begin
                ok = 1'b1;
                for (int j = 0; j < MAX_PAT_LEN; j++) begin
                    if (j < l) begin
                        pos  = k + 1 - l + j;
                        sbit = (pos < k) ? pat_bit(pattern, len, pos) : b;
                        if (pat_bit(pattern, len, j) != sbit) begin
                            ok = 1'b0;
                        end
                    end
                end
                if (ok) begin
                    best = l;
                end
            end
        end
        return best;
    endfunction

    // Progress kept after a full match when overlapping matches are allowed.
    function automatic int prefix_fail(
        input logic [MAX_PAT_LEN-1:0] pattern,
        input int                     len
    );
        return fail_len(pattern, len, len - 1, pat_bit(pattern, len, len - 1));
    endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating event counter with a synchronous clear. A clear that coincides
// with an event leaves the count at one so that event is not lost.
module seq_match_counter
    import seq_detect_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Count events, holding at the maximum, with clear taking priority
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? CNT_W'(1) : '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_detect_mealy.sv
// Parametrised Mealy serial-sequence detector with KMP fallback and a
// registered one-cycle match pulse.
// Optional feature macro: SEQ_DETECT_COUNT_EN builds the saturating match
// counter; without it match_count is tied to zero and count_clr is ignored.
module seq_detect_mealy
    import seq_detect_pkg::*;
#(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1001,
    parameter bit                 OVERLAP = 1'b0,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             din_valid,
    input  logic             din,
    input  logic             count_clr,
    output logic             dout,
    output logic [CNT_W-1:0] match_count
);

    localparam int                     SW          = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;
    localparam int                     DEPTH       = 2 ** SW;
    localparam logic [MAX_PAT_LEN-1:0] PAT_EXT     = MAX_PAT_LEN'(PATTERN);
    localparam logic [SW-1:0]          LAST        = SW'(PAT_LEN - 1);
    localparam logic [SW-1:0]          AFTER_MATCH = OVERLAP ? SW'(prefix_fail(PAT_EXT, PAT_LEN)) : '0;

    logic [SW-1:0] state;
    logic [SW-1:0] state_next;
    logic          match;
    logic          hit;

    logic          exp_bit   [DEPTH];
    logic [SW-1:0] miss_next [DEPTH];

    // Per-state expected bit and miss fallback, fixed at elaboration.
    // Unreachable encodings fall back to the empty state.
    for (genvar k = 0; k < DEPTH; k++) begin : g_table
        if (k < PAT_LEN) begin : g_live
            localparam logic EXP = pat_bit(PAT_EXT, PAT_LEN, k);
            localparam int   FB  = fail_len(PAT_EXT, PAT_LEN, k, ~EXP);
            assign exp_bit[k]   = EXP;
            assign miss_next[k] = SW'(FB);
        end else begin : g_pad
            assign exp_bit[k]   = 1'b0;
            assign miss_next[k] = '0;
        end
    end

    assign hit = (din == exp_bit[state]);

    // State register and registered match pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= '0;
            dout  <= 1'b0;
        end else begin
            state <= state_next;
            dout  <= match;
        end
    end

    // Next matched length: advance on a hit, KMP fallback on a miss, hold when idle
    always_comb begin
        state_next = state;
        if (din_valid) begin
            if (hit) begin
                if (state == LAST) begin
                    state_next = AFTER_MATCH;
                end else begin
                    state_next = state + SW'(1);
                end
            end else begin
                state_next = miss_next[state];
            end
        end
    end

    // Mealy match: the final pattern bit arrives while in the last state
    always_comb begin
        match = 1'b0;
        if (din_valid && hit && (state == LAST)) begin
            match = 1'b1;
        end
    end

`ifdef SEQ_DETECT_COUNT_EN
    seq_match_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk    (clk),
        .reset_n(reset_n),
        .inc    (match),
        .clr    (count_clr),
        .count  (match_count)
    );
`else
    logic unused_count_clr;
    assign unused_count_clr = count_clr;
    assign match_count      = '0;
`endif

endmodule

// File: tb/tb_seq_detect_mealy.sv
// Self-checking bench for seq_detect_mealy: five detector instances share one
// input stream; a history-based reference model feeds a scoreboard queue and a
// hand-derived vector table pins down the main scenarios.
module tb_seq_detect_mealy;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic din_valid = 1'b0;
    logic din = 1'b0;
    logic count_clr = 1'b0;

    logic       dout_nov, dout_ov, dout_sat, dout_p11, dout_p5;
    logic [7:0] cnt_nov, cnt_ov, cnt_p5;
    logic [1:0] cnt_sat;
    logic [3:0] cnt_p11;

    logic [4:0]  dout_vec;
    logic [31:0] cnt32 [5];

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0]       dout;
        logic [4:0][31:0] cnt;
    } exp_t;

    typedef struct packed {
        logic rst;
        logic valid;
        logic bit_in;
        logic clr;
        logic exp_nov;
        logic exp_ov;
    } vec_t;

    exp_t sb[$];

    localparam int          M_LEN [5] = '{4, 4, 4, 2, 5};
    localparam logic [31:0] M_PAT [5] = '{32'h9, 32'h9, 32'h9, 32'h3, 32'h1B};
    localparam int          M_OV  [5] = '{0, 1, 0, 1, 1};
    localparam int          M_W   [5] = '{8, 8, 2, 4, 8};

    string inst_name [5] = '{"nov", "ov", "sat", "p11", "p5"};

    logic [31:0] m_hist [5];
    int          m_hlen [5];
    int          m_cnt  [5];

    always #5 clk = ~clk;

    seq_detect_mealy #(.PAT_LEN(4), .PATTERN(4'b1001), .OVERLAP(1'b0), .CNT_W(8)) u_nov (
        .clk(clk), .reset_n(reset_n), .din_valid(din_valid), .din(din),
        .count_clr(count_clr), .dout(dout_nov), .match_count(cnt_nov));
    seq_detect_mealy #(.PAT_LEN(4), .PATTERN(4'b1001), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
        .clk(clk), .reset_n(reset_n), .din_valid(din_valid), .din(din),
        .count_clr(count_clr), .dout(dout_ov), .match_count(cnt_ov));
    seq_detect_mealy #(.PAT_LEN(4), .PATTERN(4'b1001), .OVERLAP(1'b0), .CNT_W(2)) u_sat (
        .clk(clk), .reset_n(reset_n), .din_valid(din_valid), .din(din),
        .count_clr(count_clr), .dout(dout_sat), .match_count(cnt_sat));
    seq_detect_mealy #(.PAT_LEN(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(4)) u_p11 (
        .clk(clk), .reset_n(reset_n), .din_valid(din_valid), .din(din),
        .count_clr(count_clr), .dout(dout_p11), .match_count(cnt_p11));
    seq_detect_mealy #(.PAT_LEN(5), .PATTERN(5'b11011), .OVERLAP(1'b1), .CNT_W(8)) u_p5 (
        .clk(clk), .reset_n(reset_n), .din_valid(din_valid), .din(din),
        .count_clr(count_clr), .dout(dout_p5), .match_count(cnt_p5));

    assign dout_vec = {dout_p5, dout_p11, dout_sat, dout_ov, dout_nov};
    assign cnt32[0] = 32'(cnt_nov);
    assign cnt32[1] = 32'(cnt_ov);
    assign cnt32[2] = 32'(cnt_sat);
    assign cnt32[3] = 32'(cnt_p11);
    assign cnt32[4] = 32'(cnt_p5);

    task automatic check_val(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin
            m_hist[i] = '0;
            m_hlen[i] = 0;
            m_cnt[i]  = 0;
        end
    endtask

    // Reference: a match is the pattern appearing as the newest bits of the
    // history collected since the last restart.
    task automatic model_step(input logic v, input logic d, input logic c, output exp_t e);
        logic        m;
        logic [31:0] mask;
        e = '0;
        for (int i = 0; i < 5; i++) begin
            m = 1'b0;
            if (v) begin
                m_hist[i] = {m_hist[i][30:0], d};
                if (m_hlen[i] < 32) m_hlen[i]++;
                mask = (32'd1 << M_LEN[i]) - 32'd1;
                if (m_hlen[i] >= M_LEN[i] && (m_hist[i] & mask) == M_PAT[i]) m = 1'b1;
                if (m && M_OV[i] == 0) m_hlen[i] = 0;
            end
`ifdef SEQ_DETECT_COUNT_EN
            if (c) m_cnt[i] = m ? 1 : 0;
            else if (m && m_cnt[i] < (1 << M_W[i]) - 1) m_cnt[i]++;
`else
            m_cnt[i] = c ? 0 : 0;
`endif
            e.dout[i] = m;
            e.cnt[i]  = 32'(m_cnt[i]);
        end
    endtask

    task automatic check_output();
        exp_t e;
        if (sb.size() == 0) begin
            check_val("scoreboard empty", 0, 1);
        end else begin
            e = sb.pop_front();
            for (int i = 0; i < 5; i++) begin
                check_val($sformatf("dout %s", inst_name[i]), int'(dout_vec[i]), int'(e.dout[i]));
                check_val($sformatf("count %s", inst_name[i]), int'(cnt32[i]), int'(e.cnt[i]));
            end
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic d, input logic c);
        exp_t e;
        @(negedge clk);
        din_valid = v;
        din       = d;
        count_clr = c;
        model_step(v, d, c, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_output();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        din_valid = 1'b0;
        din       = 1'b0;
        count_clr = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("reset dout %s", inst_name[i]), int'(dout_vec[i]), 0);
            check_val($sformatf("reset count %s", inst_name[i]), int'(cnt32[i]), 0);
        end
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic send_1001(input logic clr_last);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b1, clr_last);
    endtask

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs [27];
        int   exp_sat;

        // rst, valid, bit, clr, exp_nov, exp_ov
        vecs = '{
            // 1001001 continuous
            '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1},
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1},
            // 11001: miss on the second 1 keeps one bit of progress
            '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1},
            // 10 .. gap of three idle cycles .. 01
            '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1},
            // 100, reset, then 1 must not complete; full 1001 must
            '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1},
            // clear with no match
            '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}
        };

        model_reset();
        repeat (2) @(negedge clk);

        for (int n = 0; n < 27; n++) begin
            if (vecs[n].rst) do_reset();
            apply_stimulus(vecs[n].valid, vecs[n].bit_in, vecs[n].clr);
            check_val($sformatf("table %0d nov", n), int'(dout_nov), int'(vecs[n].exp_nov));
            check_val($sformatf("table %0d ov", n), int'(dout_ov), int'(vecs[n].exp_ov));
        end

        // Overlapping two-bit pattern: 111 pulses on two consecutive cycles
        do_reset();
        apply_stimulus(1'b1, 1'b1, 1'b0);
        check_val("p11 first bit", int'(dout_p11), 0);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        check_val("p11 second bit", int'(dout_p11), 1);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        check_val("p11 third bit", int'(dout_p11), 1);

        // Two-bit counter saturates, then clear coinciding with a match gives 1
        do_reset();
        for (int n = 0; n < 4; n++) send_1001(1'b0);
`ifdef SEQ_DETECT_COUNT_EN
        exp_sat = 3;
`else
        exp_sat = 0;
`endif
        check_val("sat before clear", int'(cnt_sat), exp_sat);
        send_1001(1'b1);
        check_val("sat clear dout", int'(dout_sat), 1);
`ifdef SEQ_DETECT_COUNT_EN
        exp_sat = 1;
`else
        exp_sat = 0;
`endif
        check_val("sat after clear", int'(cnt_sat), exp_sat);

        // Random traffic with idle gaps and occasional clears
        do_reset();
        for (int n = 0; n < 400; n++) begin
            apply_stimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                           $urandom_range(0, 31) == 0);
            if (n == 200) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
